aes_subbytes_pipe: RTL and testbench
====================================

AES_SUBBYTES_PIPE -- requirements
Module: aes_subbytes_pipe

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of byte lanes per beat; legal range 1..16.
REQ-002 The block SHALL have parameter TAG_W, default 4, giving the width of the sideband tag carried with each beat; legal range 1..8.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the input beat is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a beat this cycle.
REQ-007 The block SHALL have port in_data, input, 8*LANES bits; lane i is in_data[8i+7:8i].
REQ-008 The block SHALL have port in_inv, input, 1 bit: 0 selects forward S-box, 1 selects inverse S-box, per beat.
REQ-009 The block SHALL have port in_tag, input, TAG_W bits, an opaque sideband carried with the beat.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning the result beat is present.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning downstream accepts the beat.
REQ-012 The block SHALL have port out_data, output, 8*LANES bits, the substituted bytes with lane order preserved.
REQ-013 The block SHALL have port out_tag, output, TAG_W bits, the tag of the output beat unchanged.
REQ-014 The block SHALL have port busy, output, 1 bit, high while any pipeline stage holds a valid beat.

Function
REQ-015 A beat SHALL transfer on input when in_valid && in_ready, and on output when out_valid && out_ready, both at the clock edge.
REQ-016 Pipeline SHALL be 2 registered stages: S1 registers in_data/in_inv/in_tag; S2 registers the per-lane table lookup of S1 data; out_* driven directly from S2.
REQ-017 Latency SHALL be exactly 2 cycles from input transfer to out_valid with no backpressure; throughput 1 beat/cycle.
REQ-018 Stage advance SHALL be: S2 loads when !S2.valid || out_ready; S1 loads when !S1.valid || S2 loads; in_ready = !S1.valid || S2 loads (combinational from out_ready, no skid).
REQ-019 Each lane SHALL map byte b to FwdSbox[b] when the beat's inv bit is 0 and to InvSbox[b] when it is 1, per FIPS-197 tables.
REQ-020 Mode SHALL be sampled per beat; consecutive beats with differing in_inv SHALL each use their own mode with no bubble.
REQ-021 Under out_ready=0, out_data, out_tag, and out_valid SHALL hold stable until the transfer, and no beat SHALL be dropped or duplicated.
REQ-022 When the pipe is full and out_ready rises, a simultaneous output transfer and input transfer in the same cycle SHALL both occur.
REQ-023 in_data, in_inv, and in_tag SHALL be ignored when in_valid=0; data registers need not clear, but valid bits SHALL.
REQ-024 busy SHALL equal S1.valid || S2.valid.

Reset
REQ-025 While rst=1, S1.valid, S2.valid, out_valid, and busy SHALL be 0 at the next edge, and in_ready SHALL be 1 during reset.
REQ-026 Reset mid-operation SHALL discard all in-flight beats with no output after reset deasserts, and the first beat after reset SHALL have 2-cycle latency.
REQ-027 Data and tag registers SHALL NOT require reset.

Structure
REQ-028 Package aes_pkg SHALL hold the 256-entry forward and inverse S-box constant tables and the byte typedef.
REQ-029 One sub-module, aes_sbox_byte, SHALL implement the combinational 8-bit forward/inverse lookup and SHALL be instantiated LANES times via generate.
REQ-030 The block SHALL contain no latches or multi-cycle paths, and the LUT SHALL sit only between S1 and S2.

Verification
REQ-031 Forward smoke: LANES=4, in_inv=0, in_data=32'h00010203, tag=4'h5 -> after 2 cycles out_data=32'h637C777B, out_tag=4'h5.
REQ-032 Inverse and mixed mode: beats 32'h637C777B (inv=1) then 32'h53535353 (inv=0) back-to-back -> outputs 32'h00010203 then 32'hEDEDEDED on consecutive cycles.
REQ-033 Backpressure: stream 8 beats of incrementing data with out_ready toggled randomly (including held low 5 cycles) -> all 8 results in order, out_data stable while stalled, in_ready=0 when both stages are full.
REQ-034 Reset mid-flight: accept 2 beats, assert rst for 1 cycle -> out_valid=0, busy=0, no stale beat emitted, and next beat 8'hFF (LANES=1, inv=0) yields 8'h16 at 2-cycle latency.
REQ-035 Exhaustive and parameter check: LANES=1 and LANES=16, all 256 bytes in both modes -> match the aes_pkg tables, and inverse(forward(b))=b for every b.

Source files
------------

// File: rtl/aes_pkg.sv
// AES S-box constants and the byte type shared by the SubBytes pipeline.
package aes_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t FWD_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox_byte.sv
// Single-byte AES substitution, forward or inverse selected by i_inv.
module aes_sbox_byte
  import aes_pkg::*;
(
  input  byte_t i_byte,
  input  logic  i_inv,
  output byte_t o_byte
);

  // Pick the forward table unless this beat asks for the inverse
  always_comb begin
    o_byte = FWD_SBOX[i_byte];
    if (i_inv) begin
      o_byte = INV_SBOX[i_byte];
    end
  end

endmodule

// File: rtl/aes_subbytes_pipe.sv
// Two-stage AES SubBytes pipeline with valid/ready handshake and a per-beat
// forward/inverse mode. S1 captures the input beat, the lookup sits between
// S1 and S2, and the outputs come straight from S2.
module aes_subbytes_pipe
  import aes_pkg::*;
#(
  parameter int LANES = 4,
  parameter int TAG_W = 4
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  input  logic               in_inv,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  logic               r_s1Valid;
  logic [8*LANES-1:0] r_s1Data;
  logic               r_s1Inv;
  logic [TAG_W-1:0]   r_s1Tag;

  logic               r_s2Valid;
  logic [8*LANES-1:0] r_s2Data;
  logic [TAG_W-1:0]   r_s2Tag;

  logic               w_s2Load;
  logic               w_s1Load;
  logic [8*LANES-1:0] w_lutData;

  // A stage may load when it is empty or its contents move on this cycle;
  // the ready chain is purely combinational, there is no skid buffer
  always_comb begin
    w_s2Load = !r_s2Valid || out_ready;
    w_s1Load = !r_s1Valid || w_s2Load;
    in_ready = w_s1Load || rst;
    busy     = r_s1Valid || r_s2Valid;
  end

  // One table lookup per byte lane, all sharing the mode of the S1 beat
  for (genvar g = 0; g < LANES; g++) begin : gLane
    aes_sbox_byte uSbox (
      .i_byte (r_s1Data[8*g +: 8]),
      .i_inv  (r_s1Inv),
      .o_byte (w_lutData[8*g +: 8])
    );
  end

  // S1 valid bit: cleared by reset, otherwise follows in_valid when S1 loads
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1Valid <= 1'b0;
    end else if (w_s1Load) begin
      r_s1Valid <= in_valid;
    end
  end

  // S1 payload: captured only on a real input transfer, never reset
  always_ff @(posedge clk) begin
    if (w_s1Load && in_valid) begin
      r_s1Data <= in_data;
      r_s1Inv  <= in_inv;
      r_s1Tag  <= in_tag;
    end
  end

  // S2 valid bit: cleared by reset, otherwise takes S1's valid when S2 loads
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2Valid <= 1'b0;
    end else if (w_s2Load) begin
      r_s2Valid <= r_s1Valid;
    end
  end

  // S2 payload: substituted bytes and tag, held while downstream stalls
  always_ff @(posedge clk) begin
    if (w_s2Load && r_s1Valid) begin
      r_s2Data <= w_lutData;
      r_s2Tag  <= r_s1Tag;
    end
  end

  // Outputs are driven directly from the S2 registers
  always_comb begin
    out_valid = r_s2Valid;
    out_data  = r_s2Data;
    out_tag   = r_s2Tag;
  end

endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// Self-checking bench for aes_subbytes_pipe. Reference S-boxes are derived
// from GF(2^8) inversion plus the AES affine map, independent of aes_pkg.
module tb_aes_subbytes_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  logic [7:0] fwdRef [256];
  logic [7:0] invRef [256];

  // LANES=4 instance
  logic        rst4, d4InValid, d4InReady, d4InInv, d4OutValid, d4OutReady, d4Busy;
  logic [31:0] d4InData, d4OutData;
  logic [3:0]  d4InTag, d4OutTag;

  // LANES=1 instance
  logic        rst1, e1InValid, e1InReady, e1InInv, e1OutValid, e1OutReady, e1Busy;
  logic [7:0]  e1InData, e1OutData;
  logic [3:0]  e1InTag, e1OutTag;

  // LANES=16 instance
  logic         rst16, f16InValid, f16InReady, f16InInv, f16OutValid, f16OutReady, f16Busy;
  logic [127:0] f16InData, f16OutData;
  logic [3:0]   f16InTag, f16OutTag;

  aes_subbytes_pipe #(.LANES(4), .TAG_W(4)) uDut4 (
    .clk(clk), .rst(rst4), .in_valid(d4InValid), .in_ready(d4InReady),
    .in_data(d4InData), .in_inv(d4InInv), .in_tag(d4InTag),
    .out_valid(d4OutValid), .out_ready(d4OutReady), .out_data(d4OutData),
    .out_tag(d4OutTag), .busy(d4Busy)
  );

  aes_subbytes_pipe #(.LANES(1), .TAG_W(4)) uDut1 (
    .clk(clk), .rst(rst1), .in_valid(e1InValid), .in_ready(e1InReady),
    .in_data(e1InData), .in_inv(e1InInv), .in_tag(e1InTag),
    .out_valid(e1OutValid), .out_ready(e1OutReady), .out_data(e1OutData),
    .out_tag(e1OutTag), .busy(e1Busy)
  );

  aes_subbytes_pipe #(.LANES(16), .TAG_W(4)) uDut16 (
    .clk(clk), .rst(rst16), .in_valid(f16InValid), .in_ready(f16InReady),
    .in_data(f16InData), .in_inv(f16InInv), .in_tag(f16InTag),
    .out_valid(f16OutValid), .out_ready(f16OutReady), .out_data(f16OutData),
    .out_tag(f16OutTag), .busy(f16Busy)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
  } beat4_t;

  typedef struct {
    logic [31:0] data;
    logic        inv;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  beat4_t       expQ[$];
  logic [7:0]   obs1[$];
  logic [127:0] obs16[$];
  int           d4Received = 0;
  logic         stalled4 = 1'b0;
  logic [31:0]  holdData;
  logic [3:0]   holdTag;
  logic [127:0] sbTmp;

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0b, expected %0b", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    for (int c = 1; c < 256; c++) begin
      if (gmul(a, 8'(c)) == 8'h01) return 8'(c);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // Build the reference tables from the field arithmetic definition
  task automatic buildModel();
    for (int b = 0; b < 256; b++) begin
      logic [7:0] q;
      logic [7:0] s;
      q = ginv(8'(b));
      s = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4) ^ 8'h63;
      fwdRef[b] = s;
      invRef[s] = 8'(b);
    end
  endtask

  function automatic logic [127:0] subLanes(input logic [127:0] d, input logic inv, input int lanes);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < lanes; i++) begin
      r[8*i +: 8] = inv ? invRef[d[8*i +: 8]] : fwdRef[d[8*i +: 8]];
    end
    return r;
  endfunction

  // Scoreboard for the LANES=4 instance: inputs accepted at the coming edge
  // are queued with their expected result, outputs are checked in order,
  // and a stalled output must not change until it is taken
  always @(negedge clk) begin
    if (rst4) begin
      expQ.delete();
      stalled4 <= 1'b0;
    end else begin
      if (stalled4) begin
        checkBit("stall hold valid", d4OutValid, 1'b1);
        checkOutput("stall hold data", 128'(d4OutData), 128'(holdData));
        checkOutput("stall hold tag", 128'(d4OutTag), 128'(holdTag));
      end
      stalled4 <= d4OutValid && !d4OutReady;
      holdData <= d4OutData;
      holdTag  <= d4OutTag;
      if (d4OutValid && d4OutReady) begin
        d4Received <= d4Received + 1;
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL sb unexpected beat: got %0h, expected none", d4OutData);
        end else begin
          beat4_t e;
          e = expQ.pop_front();
          checkOutput("sb data", 128'(d4OutData), 128'(e.data));
          checkOutput("sb tag", 128'(d4OutTag), 128'(e.tag));
        end
      end
      if (d4InValid && d4InReady) begin
        sbTmp = subLanes(128'(d4InData), d4InInv, 4);
        expQ.push_back('{data: sbTmp[31:0], tag: d4InTag});
      end
    end
  end

  // Collect delivered beats of the narrow and wide instances
  always @(negedge clk) begin
    if (!rst1 && e1OutValid && e1OutReady) obs1.push_back(e1OutData);
    if (!rst16 && f16OutValid && f16OutReady) obs16.push_back(f16OutData);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t         vecs[7];
    int           sent;
    int           cyc;
    int           startRecv;
    int           waitCyc;
    logic         willXfer;
    logic [127:0] beat;
    logic [127:0] fwdBeats[16];

    buildModel();

    rst4 = 1'b1; rst1 = 1'b1; rst16 = 1'b1;
    d4InValid = 1'b0; d4InData = '0; d4InInv = 1'b0; d4InTag = '0; d4OutReady = 1'b1;
    e1InValid = 1'b0; e1InData = '0; e1InInv = 1'b0; e1InTag = '0; e1OutReady = 1'b1;
    f16InValid = 1'b0; f16InData = '0; f16InInv = 1'b0; f16InTag = '0; f16OutReady = 1'b1;
    tick();
    tick();
    checkBit("reset outValid", d4OutValid, 1'b0);
    checkBit("reset busy", d4Busy, 1'b0);
    checkBit("reset inReady", d4InReady, 1'b1);
    checkBit("reset outValid lanes1", e1OutValid, 1'b0);
    checkBit("reset outValid lanes16", f16OutValid, 1'b0);
    rst4 = 1'b0; rst1 = 1'b0; rst16 = 1'b0;
    tick();
    checkBit("post reset outValid", d4OutValid, 1'b0);
    checkBit("post reset busy", d4Busy, 1'b0);

    // Single beats through an idle pipe: two-cycle latency, then drain
    vecs[0] = '{32'h00010203, 1'b0, 4'h5, 32'h637C777B};
    vecs[1] = '{32'h637C777B, 1'b1, 4'hA, 32'h00010203};
    vecs[2] = '{32'h53535353, 1'b0, 4'h3, 32'hEDEDEDED};
    vecs[3] = '{32'hFFFFFFFF, 1'b0, 4'hF, 32'h16161616};
    vecs[4] = '{32'h00000000, 1'b1, 4'h0, 32'h52525252};
    vecs[5] = '{32'h16161616, 1'b1, 4'h9, 32'hFFFFFFFF};
    vecs[6] = '{32'h10203040, 1'b0, 4'h6, 32'hCAB70409};
    for (int i = 0; i < 7; i++) begin
      d4InValid = 1'b1;
      d4InData  = vecs[i].data;
      d4InInv   = vecs[i].inv;
      d4InTag   = vecs[i].tag;
      tick();
      d4InValid = 1'b0;
      d4InData  = $urandom;
      d4InInv   = 1'($urandom_range(0, 1));
      d4InTag   = 4'($urandom);
      checkBit("vec cycle1 outValid", d4OutValid, 1'b0);
      checkBit("vec cycle1 busy", d4Busy, 1'b1);
      tick();
      checkBit("vec cycle2 outValid", d4OutValid, 1'b1);
      checkOutput("vec data", 128'(d4OutData), 128'(vecs[i].exp));
      checkOutput("vec tag", 128'(d4OutTag), 128'(vecs[i].tag));
      tick();
      checkBit("vec drained outValid", d4OutValid, 1'b0);
      checkBit("vec drained busy", d4Busy, 1'b0);
    end

    // Back-to-back beats with differing modes come out on consecutive cycles
    d4InValid = 1'b1; d4InData = 32'h637C777B; d4InInv = 1'b1; d4InTag = 4'h1;
    tick();
    d4InData = 32'h53535353; d4InInv = 1'b0; d4InTag = 4'h2;
    tick();
    d4InValid = 1'b0;
    checkBit("mixed first valid", d4OutValid, 1'b1);
    checkOutput("mixed first data", 128'(d4OutData), 128'h00010203);
    checkOutput("mixed first tag", 128'(d4OutTag), 128'h1);
    tick();
    checkBit("mixed second valid", d4OutValid, 1'b1);
    checkOutput("mixed second data", 128'(d4OutData), 128'hEDEDEDED);
    checkOutput("mixed second tag", 128'(d4OutTag), 128'h2);
    tick();
    checkBit("mixed drained", d4OutValid, 1'b0);

    // Eight incrementing beats, output held low five cycles, then random
    startRecv = d4Received;
    sent = 0;
    cyc = 0;
    d4OutReady = 1'b0;
    while (sent < 8 && cyc < 300) begin
      d4InValid = 1'b1;
      d4InData  = 32'h00010203 + 32'(sent) * 32'h04040404;
      d4InInv   = 1'b0;
      d4InTag   = 4'(sent);
      if (cyc == 5) d4OutReady = 1'b1;
      else if (cyc > 5) d4OutReady = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (cyc == 4) begin
        checkBit("bp full inReady", d4InReady, 1'b0);
        checkBit("bp full outValid", d4OutValid, 1'b1);
        checkBit("bp full busy", d4Busy, 1'b1);
      end
      if (cyc == 5) checkBit("bp release inReady", d4InReady, 1'b1);
      willXfer = d4InReady;
      @(posedge clk);
      #1;
      if (willXfer) sent++;
      cyc++;
    end
    checkOutput("bp beats sent", 128'(sent), 128'(8));
    d4InValid = 1'b0;
    waitCyc = 0;
    while (expQ.size() != 0 && waitCyc < 100) begin
      d4OutReady = 1'($urandom_range(0, 1));
      tick();
      waitCyc++;
    end
    d4OutReady = 1'b1;
    tick();
    checkOutput("bp beats received", 128'(d4Received - startRecv), 128'(8));

    // Random traffic in both modes against the scoreboard
    for (int c = 0; c < 400; c++) begin
      d4InValid  = 1'($urandom_range(0, 1));
      d4InData   = $urandom;
      d4InInv    = 1'($urandom_range(0, 1));
      d4InTag    = 4'($urandom);
      d4OutReady = ($urandom_range(0, 3) != 0);
      tick();
    end
    d4InValid = 1'b0;
    waitCyc = 0;
    while (expQ.size() != 0 && waitCyc < 100) begin
      d4OutReady = 1'b1;
      tick();
      waitCyc++;
    end
    checkOutput("random drain pending", 128'(expQ.size()), 128'(0));

    // Reset with a full pipe discards both beats; next beat has normal latency
    e1OutReady = 1'b0;
    e1InValid = 1'b1; e1InData = 8'h11; e1InInv = 1'b0;
    tick();
    e1InData = 8'h22;
    tick();
    e1InValid = 1'b0;
    checkBit("pre-reset full inReady", e1InReady, 1'b0);
    rst1 = 1'b1;
    #1;
    checkBit("in-reset inReady", e1InReady, 1'b1);
    tick();
    rst1 = 1'b0;
    e1OutReady = 1'b1;
    obs1.delete();
    checkBit("after reset outValid", e1OutValid, 1'b0);
    checkBit("after reset busy", e1Busy, 1'b0);
    tick();
    checkBit("no stale outValid", e1OutValid, 1'b0);
    e1InValid = 1'b1; e1InData = 8'hFF; e1InInv = 1'b0; e1InTag = 4'h7;
    tick();
    e1InValid = 1'b0;
    checkBit("post reset cycle1 outValid", e1OutValid, 1'b0);
    tick();
    checkBit("post reset cycle2 outValid", e1OutValid, 1'b1);
    checkOutput("post reset data", 128'(e1OutData), 128'h16);
    checkOutput("post reset tag", 128'(e1OutTag), 128'h7);
    tick();
    checkOutput("post reset beat count", 128'(obs1.size()), 128'(1));

    // Every byte in both modes through the single-lane instance
    obs1.delete();
    for (int m = 0; m < 2; m++) begin
      for (int b = 0; b < 256; b++) begin
        e1InValid = 1'b1;
        e1InData  = 8'(b);
        e1InInv   = 1'(m);
        tick();
      end
    end
    e1InValid = 1'b0;
    tick(); tick(); tick();
    checkOutput("exhaustive lanes1 count", 128'(obs1.size()), 128'(512));
    for (int i = 0; i < 512 && i < obs1.size(); i++) begin
      checkOutput("exhaustive lanes1", 128'(obs1[i]), 128'(i < 256 ? fwdRef[i] : invRef[i - 256]));
    end

    // Sixteen lanes: forward over all bytes, then inverse of those results
    obs16.delete();
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) beat[8*i +: 8] = 8'(16*k + i);
      f16InValid = 1'b1; f16InData = beat; f16InInv = 1'b0; f16InTag = 4'(k);
      tick();
    end
    f16InValid = 1'b0;
    tick(); tick(); tick();
    checkOutput("lanes16 fwd count", 128'(obs16.size()), 128'(16));
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) beat[8*i +: 8] = 8'(16*k + i);
      fwdBeats[k] = (k < obs16.size()) ? obs16[k] : '0;
      checkOutput("lanes16 fwd", fwdBeats[k], subLanes(beat, 1'b0, 16));
    end
    obs16.delete();
    for (int k = 0; k < 16; k++) begin
      f16InValid = 1'b1; f16InData = fwdBeats[k]; f16InInv = 1'b1; f16InTag = 4'(k);
      tick();
    end
    f16InValid = 1'b0;
    tick(); tick(); tick();
    checkOutput("lanes16 roundtrip count", 128'(obs16.size()), 128'(16));
    for (int k = 0; k < 16 && k < obs16.size(); k++) begin
      for (int i = 0; i < 16; i++) beat[8*i +: 8] = 8'(16*k + i);
      checkOutput("lanes16 roundtrip", obs16[k], beat);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
